// File: rtl/avalon_uart_fifo.sv
// avalon_uart_fifo: Avalon-MM serial UART with TX/RX FIFOs, runtime baud
// divisor, sticky error flags and a level interrupt.
module avalon_uart_fifo #(
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 64,
  parameter int RX_DEPTH  = 64,
  parameter int DIV_WIDTH = 16,
  parameter int DIV_RESET = 433
) (
  input  logic        clock_clk,
  input  logic        reset_reset_n,
  input  logic        slave_chipselect,
  input  logic [1:0]  slave_address,
  input  logic        slave_read_n,
  output logic [31:0] slave_readdata,
  input  logic        slave_write_n,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic        irq_irq,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
  localparam logic [TCW-1:0] TX_HALF_CNT = TCW'(TX_DEPTH / 2);
  localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);
  localparam logic [BW-1:0]  LAST_BIT    = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Divisor writes saturate at the minimum usable bit period.
  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] w);
    logic [DIV_WIDTH-1:0] v;
    v = w;
    if (v < DIV_WIDTH'(3)) v = DIV_WIDTH'(3);
    return v;
  endfunction

  // Register file and bus state
  logic [DIV_WIDTH-1:0] div_reg;
  logic                 re, we, rx_ovf, fe, tx_ovf;
  logic                 rd_vld_p0;
  logic [31:0]          rd_val;

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0]       tx_wp, tx_rp;
  logic [TCW-1:0]       tx_cnt, tx_space;
  logic                 tx_full, tx_push, tx_pop;

  // RX FIFO
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RAW-1:0]       rx_wp, rx_rp;
  logic [RCW-1:0]       rx_cnt;
  logic                 rx_full, rx_push, rx_pop;

  // TX engine
  state_t               tx_state;
  logic [DIV_WIDTH-1:0] tx_clk, tx_div_l;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_bit_end;

  // RX engine
  logic                 rxd_p0, rxd_p1, rxd_p2;
  state_t               rx_state;
  logic [DIV_WIDTH-1:0] rx_clk, rx_div_l;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_stop_pt, fe_set, rx_ovf_set;

  logic rd_req, wr_req, ri, wi;
  logic wdata_unused;

  // Upper write-data bits have no register behind them.
  assign wdata_unused = ^slave_writedata;

  assign rd_req            = slave_chipselect & ~slave_read_n;
  assign wr_req            = slave_chipselect & ~slave_write_n;
  assign slave_waitrequest = rd_req & ~rd_vld_p0;

  assign tx_full  = (tx_cnt == TX_FULL_CNT);
  assign tx_space = TX_FULL_CNT - tx_cnt;
  assign tx_push  = wr_req & (slave_address == 2'd0) & ~tx_full;
  assign tx_bit_end = (tx_clk == tx_div_l);
  assign tx_pop   = (tx_cnt != '0) &
                    ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_bit_end));

  assign rx_full    = (rx_cnt == RX_FULL_CNT);
  assign rx_stop_pt = (rx_state == S_STOP) & (rx_clk == rx_div_l);
  assign rx_push    = rx_stop_pt & rxd_p1 & ~rx_full;
  assign rx_ovf_set = rx_stop_pt & rxd_p1 & rx_full;
  assign fe_set     = rx_stop_pt & ~rxd_p1;
  // Pop only when the data phase of a DATA read returned a valid char.
  assign rx_pop     = rd_req & rd_vld_p0 & (slave_address == 2'd0) & slave_readdata[15];

  assign ri = re & (rx_cnt != '0);
  assign wi = we & (tx_space >= TX_HALF_CNT);

  // Register read mux, captured in the wait-state cycle.
  always_comb begin
    rd_val = '0;
    case (slave_address)
      2'd0: begin
        if (rx_cnt != '0) rd_val[DATA_BITS-1:0] = rx_mem[rx_rp];
        rd_val[15]       = (rx_cnt != '0);
        rd_val[16 +: RCW] = rx_cnt;
      end
      2'd1: begin
        rd_val[0]         = re;
        rd_val[1]         = we;
        rd_val[8]         = ri;
        rd_val[9]         = wi;
        rd_val[10]        = rx_ovf;
        rd_val[11]        = fe;
        rd_val[12]        = tx_ovf;
        rd_val[16 +: TCW] = tx_space;
      end
      2'd2: rd_val[DIV_WIDTH-1:0] = div_reg;
      default: rd_val = '0;
    endcase
  end

  // Bus stage: one wait state on reads, zero on writes; sticky flags set wins over clear.
  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) begin
      rd_vld_p0      <= 1'b0;
      slave_readdata <= '0;
      re             <= 1'b0;
      we             <= 1'b0;
      rx_ovf         <= 1'b0;
      fe             <= 1'b0;
      tx_ovf         <= 1'b0;
      div_reg        <= DIV_WIDTH'(DIV_RESET);
    end else begin
      if (rd_req) begin
        rd_vld_p0 <= ~rd_vld_p0;
        if (!rd_vld_p0) slave_readdata <= rd_val;
      end else begin
        rd_vld_p0 <= 1'b0;
      end
      if (wr_req && slave_address == 2'd1) begin
        re <= slave_writedata[0];
        we <= slave_writedata[1];
        if (slave_writedata[10]) rx_ovf <= 1'b0;
        if (slave_writedata[11]) fe     <= 1'b0;
        if (slave_writedata[12]) tx_ovf <= 1'b0;
      end
      if (wr_req && slave_address == 2'd2)
        div_reg <= clamp_div(slave_writedata[DIV_WIDTH-1:0]);
      if (rx_ovf_set) rx_ovf <= 1'b1;
      if (fe_set)     fe     <= 1'b1;
      if (wr_req && slave_address == 2'd0 && tx_full) tx_ovf <= 1'b1;
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // TX FIFO storage.
  always_ff @(posedge clock_clk) begin
    if (tx_push) tx_mem[tx_wp] <= slave_writedata[DATA_BITS-1:0];
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // RX FIFO storage.
  always_ff @(posedge clock_clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_shreg;
  end

  // TX FSM; uart_txd is registered from the current state, so it trails the state by one cycle.
  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) begin
      tx_state <= S_IDLE;
      tx_clk   <= '0;
      tx_bit   <= '0;
      uart_txd <= 1'b1;
    end else begin
      case (tx_state)
        S_START: uart_txd <= 1'b0;
        S_DATA:  uart_txd <= tx_shreg[0];
        default: uart_txd <= 1'b1;
      endcase
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_state <= S_START;
            tx_clk   <= '0;
            tx_shreg <= tx_mem[tx_rp];
            tx_div_l <= div_reg;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx_clk   <= '0;
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end else begin
            tx_clk <= tx_clk + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_clk   <= '0;
            tx_shreg <= tx_shreg >> 1;
            if (tx_bit == LAST_BIT) tx_state <= S_STOP;
            else                    tx_bit   <= tx_bit + 1'b1;
          end else begin
            tx_clk <= tx_clk + 1'b1;
          end
        end
        default: begin
          if (tx_bit_end) begin
            tx_clk <= '0;
            if (tx_pop) begin
              tx_state <= S_START;
              tx_shreg <= tx_mem[tx_rp];
              tx_div_l <= div_reg;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_clk <= tx_clk + 1'b1;
          end
        end
      endcase
    end
  end

  // RX synchroniser stage (p0, p1) plus one delayed copy (p2) for falling-edge detect.
  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= uart_rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  // RX FSM: start checked at half a bit, later bits sampled one full period apart (mid-bit).
  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) begin
      rx_state <= S_IDLE;
      rx_clk   <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rxd_p2 && !rxd_p1) begin
            rx_state <= S_START;
            rx_clk   <= '0;
            rx_div_l <= div_reg;
          end
        end
        S_START: begin
          if (rx_clk == (rx_div_l >> 1)) begin
            rx_clk   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_p1 ? S_IDLE : S_DATA;
          end else begin
            rx_clk <= rx_clk + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_clk == rx_div_l) begin
            rx_clk   <= '0;
            rx_shreg <= {rxd_p1, rx_shreg[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) rx_state <= S_STOP;
            else                    rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_clk <= rx_clk + 1'b1;
          end
        end
        default: begin
          if (rx_stop_pt) begin
            rx_clk   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_clk <= rx_clk + 1'b1;
          end
        end
      endcase
    end
  end

  // Interrupt stage: registered RI | WI.
  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) irq_irq <= 1'b0;
    else                irq_irq <= ri | wi;
  end

endmodule

// File: tb/tb_avalon_uart_fifo.sv
// Testbench for avalon_uart_fifo: register access, TX framing, RX loopback,
// framing error, interrupt and FIFO overflow scenarios.
module tb_avalon_uart_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] wdata = '0;
  logic [31:0] readdata;
  logic        waitreq;
  logic        irq;
  logic        txd;
  logic        rxd_drv = 1'b1;
  logic        loop = 1'b0;
  logic        rxd;

  int checks = 0;
  int errors = 0;

  // Falling edges seen on uart_txd, used to count transmitted frames of 0xFF.
  int   falls = 0;
  logic txd_q = 1'b1;

  assign rxd = loop ? txd : rxd_drv;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (txd_q && !txd) falls <= falls + 1;
    txd_q <= txd;
  end

  avalon_uart_fifo dut (
    .clock_clk         (clk),
    .reset_reset_n     (reset_n),
    .slave_chipselect  (cs),
    .slave_address     (addr),
    .slave_read_n      (read_n),
    .slave_readdata    (readdata),
    .slave_write_n     (write_n),
    .slave_writedata   (wdata),
    .slave_waitrequest (waitreq),
    .irq_irq           (irq),
    .uart_rxd          (rxd),
    .uart_txd          (txd)
  );

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write_n = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d,
                          output logic w1, output logic w2);
    @(negedge clk);
    cs = 1'b1; read_n = 1'b0; addr = a;
    #1 w1 = waitreq;
    @(negedge clk);
    w2 = waitreq;
    d  = readdata;
    @(posedge clk);
    #1 cs = 1'b0; read_n = 1'b1;
  endtask

  // Bit-bang one frame onto the RX pin; bp = clocks per bit.
  task automatic send_frame(input logic [7:0] ch, input logic stop, input int bp);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = ch[i];
      repeat (bp) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (bp) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (bp) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic w1, w2;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({txd, irq, waitreq} !== 3'b100 || readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_pins: txd/irq/wait=%b readdata=%h required 100 / 00000000",
               {txd, irq, waitreq}, readdata);
    end
    bus_read(2'd0, d, w1, w2);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 00000000", d); end
    checks++;
    if ({w1, w2} !== 2'b10) begin errors++; $display("FAIL read_waitstate: got %b required 10", {w1, w2}); end
    bus_read(2'd1, d, w1, w2);
    checks++;
    if (d !== 32'h0040_0000) begin errors++; $display("FAIL reset_control: got %h required 00400000", d); end
    bus_read(2'd2, d, w1, w2);
    checks++;
    if (d !== 32'd433) begin errors++; $display("FAIL reset_divisor: got %0d required 433", d); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d, w1, w2);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL addr3: got %h required 00000000", d); end
  endtask

  task automatic test_divisor;
    logic [31:0] d;
    logic w1, w2;
    logic [15:0] v;
    bus_write(2'd2, 32'd1);
    bus_read(2'd2, d, w1, w2);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL div_clamp: got %0d required 3", d); end
    v = 16'($urandom_range(3, 60000));
    bus_write(2'd2, {16'hABCD, v});
    bus_read(2'd2, d, w1, w2);
    checks++;
    if (d !== {16'h0, v}) begin errors++; $display("FAIL div_rw: got %0d required %0d", d, v); end
  endtask

  task automatic test_tx_frame;
    logic [7:0] chars [2];
    logic       lv [10];
    int         bad;
    chars[0] = 8'hA5;
    chars[1] = 8'($urandom);
    bus_write(2'd2, 32'd9);
    for (int c = 0; c < 2; c++) begin
      lv[0] = 1'b0;
      for (int i = 0; i < 8; i++) lv[1 + i] = (((chars[c] >> i) & 8'd1) != 8'd0);
      lv[9] = 1'b1;
      bus_write(2'd0, {24'h0, chars[c]});
      // Write edge was one cycle ago; the line must still be high for two samples.
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL tx_latency_a: txd=%b required 1", txd); end
      @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL tx_latency_b: txd=%b required 1", txd); end
      @(negedge clk);
      for (int b = 0; b < 10; b++) begin
        bad = 0;
        for (int j = 0; j < 10; j++) begin
          if (b != 0 || j != 0) @(negedge clk);
          if (txd !== lv[b]) bad++;
        end
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL tx_bit char=%h bit=%0d: %0d samples off, required level %b for 10 cycles",
                   chars[c], b, bad, lv[b]);
        end
      end
      @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL tx_idle_after: txd=%b required 1", txd); end
    end
  endtask

  task automatic test_rx_loopback;
    logic [31:0] d;
    logic w1, w2;
    logic [7:0] q [$];
    logic [7:0] ch;
    logic [31:0] exp;
    loop = 1'b1;
    bus_write(2'd0, 32'h3C);
    repeat (130) @(negedge clk);
    bus_read(2'd0, d, w1, w2);
    checks++;
    if (d !== 32'h0001_803C) begin errors++; $display("FAIL loop_first: got %h required 0001803C", d); end
    bus_read(2'd0, d, w1, w2);
    checks++;
    if (d[15] !== 1'b0 || d[31:16] !== 16'h0) begin
      errors++; $display("FAIL loop_empty: got %h required RVALID=0 RAVAIL=0", d);
    end
    for (int i = 0; i < 3; i++) begin
      ch = 8'($urandom);
      q.push_back(ch);
      bus_write(2'd0, {24'h0, ch});
    end
    repeat (360) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp = {16'(q.size()), 1'b1, 7'h0, q[0]};
      void'(q.pop_front());
      bus_read(2'd0, d, w1, w2);
      checks++;
      if (d !== exp) begin errors++; $display("FAIL loop_rand%0d: got %h required %h", i, d, exp); end
    end
    loop = 1'b0;
  endtask

  task automatic test_framing_error;
    logic [31:0] d;
    logic w1, w2;
    logic [7:0] ch;
    send_frame(8'($urandom), 1'b0, 10);
    bus_read(2'd1, d, w1, w2);
    checks++;
    if (d[11] !== 1'b1) begin errors++; $display("FAIL fe_set: control=%h required FE=1", d); end
    bus_read(2'd0, d, w1, w2);
    checks++;
    if (d[15] !== 1'b0) begin errors++; $display("FAIL fe_nopush: data=%h required RVALID=0", d); end
    bus_write(2'd1, 32'h800);
    bus_read(2'd1, d, w1, w2);
    checks++;
    if (d[11] !== 1'b0) begin errors++; $display("FAIL fe_clear: control=%h required FE=0", d); end
    ch = 8'($urandom);
    send_frame(ch, 1'b1, 10);
    bus_read(2'd0, d, w1, w2);
    checks++;
    if (d !== {16'd1, 1'b1, 7'h0, ch}) begin
      errors++; $display("FAIL rx_pin_frame: got %h required %h", d, {16'd1, 1'b1, 7'h0, ch});
    end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    logic w1, w2;
    logic [7:0] ch;
    bus_write(2'd1, 32'h1);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_re_empty: irq=%b required 0", irq); end
    ch = 8'($urandom);
    send_frame(ch, 1'b1, 10);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx: irq=%b required 1", irq); end
    bus_read(2'd0, d, w1, w2);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_pop: irq=%b required 0", irq); end
    bus_write(2'd1, 32'h3);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_we: irq=%b required 1", irq); end
    bus_read(2'd1, d, w1, w2);
    checks++;
    if (d !== 32'h0040_0203) begin errors++; $display("FAIL control_ri_wi: got %h required 00400203", d); end
    bus_write(2'd1, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_off: irq=%b required 0", irq); end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    logic w1, w2;
    int occ, drops, next_pop, frame, base;
    bit pop, push;
    // Occupancy model: the transmitter takes one entry the cycle after the
    // first write and another every frame (10 bits of DIVISOR+1 clocks).
    frame = 10 * (3 + 1);
    occ = 0; drops = 0; next_pop = 1;
    for (int k = 0; k < 70; k++) begin
      push = (occ < 64);
      pop  = (k == next_pop) && (occ > 0);
      if (pop) next_pop += frame;
      if (!push) drops++;
      occ += (push ? 1 : 0) - (pop ? 1 : 0);
    end
    bus_write(2'd2, 32'd3);
    loop = 1'b1;
    base = falls;
    @(negedge clk);
    cs = 1'b1; write_n = 1'b0; addr = 2'd0;
    for (int k = 0; k < 70; k++) begin
      wdata = 32'hFF;
      @(negedge clk);
    end
    cs = 1'b0; write_n = 1'b1;
    bus_read(2'd1, d, w1, w2);
    checks++;
    if (d[12] !== 1'b1) begin errors++; $display("FAIL tx_ovf: control=%h required TX_OVF=1", d); end
    repeat (3000) @(negedge clk);
    checks++;
    if (falls - base != 70 - drops) begin
      errors++; $display("FAIL tx_frames_sent: got %0d required %0d", falls - base, 70 - drops);
    end
    bus_read(2'd1, d, w1, w2);
    checks++;
    if (d[10] !== 1'b1 || d[31:16] !== 16'd64) begin
      errors++; $display("FAIL rx_ovf: control=%h required RX_OVF=1 WSPACE=64", d);
    end
    bus_read(2'd0, d, w1, w2);
    checks++;
    if (d !== 32'h0040_80FF) begin errors++; $display("FAIL rx_full_data: got %h required 004080FF", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic w1, w2;
    loop = 1'b0;
    bus_write(2'd2, 32'd9);
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'h00);
    repeat (30) @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin errors++; $display("FAIL mid_frame_low: txd=%b required 0", txd); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || readdata !== 32'h0) begin
      errors++; $display("FAIL reset_abort: txd=%b readdata=%h required 1 / 00000000", txd, readdata);
    end
    reset_n = 1'b1;
    bus_read(2'd1, d, w1, w2);
    checks++;
    if (d !== 32'h0040_0000) begin errors++; $display("FAIL reset_mid_control: got %h required 00400000", d); end
    bus_read(2'd2, d, w1, w2);
    checks++;
    if (d !== 32'd433) begin errors++; $display("FAIL reset_mid_div: got %0d required 433", d); end
    repeat (20) @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_tx_idle: txd=%b required 1", txd); end
  endtask

  initial begin
    test_reset;
    test_divisor;
    test_tx_frame;
    test_rx_loopback;
    test_framing_error;
    test_irq;
    test_overflow;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
